// File: rtl/seq_radix_multiplier.sv
// seq_radix_multiplier: sequential unsigned multiplier that consumes the
// multiplier `digit` bits per clock, least-significant digit first.
// Finishes early once the remaining multiplier bits are all zero.
// Optional feature macro: MUL_OVF_DETECT_EN.
//   Defined   -> the accumulator holds the full aWidth+bWidth product and
//                ovf reports whether that product needs more than `width` bits.
//   Undefined -> the accumulator is `width` bits and ovf is tied to 0.
module seq_radix_multiplier #(
  parameter int width  = 32,
  parameter int aWidth = 28,
  parameter int bWidth = 8,
  parameter int digit  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [aWidth-1:0] A,
  input  logic [bWidth-1:0] b,
  output logic [width-1:0]  c,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  // Number of multiplier digits and the width of the digit index.
  localparam int NDIG  = bWidth / digit;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

`ifdef MUL_OVF_DETECT_EN
  // Full-product accumulator so that bits above `width` can be observed.
  localparam int ACC_W = aWidth + bWidth;
`else
  // Product is only needed modulo 2^width.
  localparam int ACC_W = width;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [aWidth-1:0]   r_a;
  logic [bWidth-1:0]   r_b;
  logic [IDX_W-1:0]    r_idx;
  logic [ACC_W-1:0]    r_acc;
  logic [width-1:0]    r_c;
  logic                r_busy;
  logic                r_done;

  logic                w_load;
  logic                w_step;
  logic                w_finish;
  logic                w_last;
  logic [bWidth-1:0]   w_b_shift;
  logic [31:0]         w_shamt;
  logic [ACC_W-1:0]    w_pp;
  logic [ACC_W-1:0]    w_acc_next;

  // Datapath for one digit: partial product, its weight, and the new accumulator.
  always_comb begin
    w_b_shift  = r_b >> digit;
    w_shamt    = 32'(r_idx) * 32'(digit);
    w_pp       = ACC_W'(r_a) * ACC_W'(r_b[digit-1:0]);
    w_acc_next = r_acc + (w_pp << w_shamt);
    // Last digit reached, or nothing nonzero left to multiply by.
    w_last     = (r_idx == IDX_W'(NDIG - 1)) || (w_b_shift == '0);
  end

  // Next-state decode and datapath strobes for the IDLE/CALC/DONE sequence.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_CALC;
          w_load       = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_CALC: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
          w_finish     = 1'b1;
        end else begin
          w_state_next = S_CALC;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State register; reset returns to IDLE from anywhere, including mid-CALC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand latch, digit index and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
      r_acc <= '0;
    end else if (w_load) begin
      r_a   <= A;
      r_b   <= b;
      r_idx <= '0;
      r_acc <= '0;
    end else if (w_step) begin
      r_acc <= w_acc_next;
      r_b   <= w_b_shift;
      r_idx <= r_idx + IDX_W'(1);
    end else begin
      r_acc <= r_acc;
    end
  end

  // Result register: loaded only on the CALC->DONE edge, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c <= '0;
    end else if (w_finish) begin
      r_c <= width'(w_acc_next);
    end else begin
      r_c <= r_c;
    end
  end

  // Registered status flags, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_next == S_CALC);
      r_done <= (w_state_next == S_DONE);
    end
  end

`ifdef MUL_OVF_DETECT_EN
  logic r_ovf;

  // Overflow flag: any product bit at or above `width`, updated with c.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_finish) begin
      r_ovf <= ((w_acc_next >> width) != '0);
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign c    = r_c;
  assign busy = r_busy;
  assign done = r_done;

endmodule
